fetch_pc_gen: RTL and testbench

- Fetch-side consumer of resolved branch targets: owns the architectural fetch PC and drives the instruction-memory request handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Accepts redirects (taken branch/jump target) from execute and discards any fetch in flight to a stale PC.

---
 rtl/fetch_pc_gen.sv | 114 +++++++++++
 tb/tb_fetch_pc_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: owns the fetch PC, drives the imem request and presents instructions to decode.
// Optional: FETCH_MISALIGN_CHECK_EN drops misaligned redirects and pulses misalign_err.
module fetch_pc_gen #(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [WordSize-1:0] if_pc,
    output logic [31:0]         if_instr,
    input  logic                if_ready
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t              state;
    logic [WordSize-1:0] pc;
    logic [WordSize-1:0] req_addr;
    logic [WordSize-1:0] pc_next;
    logic [WordSize-1:0] tgt;
    logic                take;

    assign pc_next = pc + WordSize'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign take = redirect_valid && (redirect_addr[1:0] == 2'b00);
    assign tgt  = redirect_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= redirect_valid && (redirect_addr[1:0] != 2'b00);
    end
`else
    assign take = redirect_valid;
    assign tgt  = {redirect_addr[WordSize-1:2], 2'b00};
`endif

    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign if_valid  = (state == HOLD);
    assign imem_addr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= ResetVector;
            req_addr <= ResetVector;
            if_pc    <= ResetVector;
            if_instr <= '0;
        end else if (take) begin
            // Redirect wins; an in-flight request to a stale PC must drain first.
            pc <= tgt;
            unique case (state)
                IDLE, HOLD: begin
                    state    <= REQ;
                    req_addr <= tgt;
                end
                REQ: begin
                    if (imem_ack) req_addr <= tgt;
                    else          state    <= DRAIN;
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state    <= REQ;
                        req_addr <= tgt;
                    end
                end
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    req_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= req_addr;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        pc       <= pc_next;
                        req_addr <= pc_next;
                        state    <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        req_addr <= pc;
                        state    <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed plan steps then random traffic vs a transaction-level fetch model.
// Builds with or without FETCH_MISALIGN_CHECK_EN.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    // Reference: started / fetch pc / address on the bus / stale-request flag / held instruction.
    bit          m_started;
    bit          m_stale;
    bit          m_held;
    bit          m_err;
    logic [31:0] m_pc;
    logic [31:0] m_req;
    logic [31:0] m_hpc;
    logic [31:0] m_hin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_stale   = 0;
        m_held    = 0;
        m_err     = 0;
        m_pc      = 32'h0;
        m_req     = 32'h0;
        m_hpc     = 32'h0;
        m_hin     = 32'h0;
    endtask

    task automatic check_outputs();
        bit busy;
        busy = m_started && !m_held;
        chk("imem_req", {31'b0, imem_req}, {31'b0, busy});
        if (busy) chk("imem_addr", imem_addr, m_req);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_held});
        if (m_held) begin
            chk("if_pc", if_pc, m_hpc);
            chk("if_instr", if_instr, m_hin);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
`endif
    endtask

    task automatic model_update(input bit rv, input logic [31:0] ra,
                                input bit ack, input logic [31:0] rd, input bit rdy);
        bit          take;
        logic [31:0] t;
`ifdef FETCH_MISALIGN_CHECK_EN
        take  = rv && (ra[1:0] == 2'b00);
        m_err = rv && (ra[1:0] != 2'b00);
        t     = ra;
`else
        take  = rv;
        t     = ra & 32'hFFFF_FFFC;
`endif
        if (!m_started) begin
            m_started = 1;
            if (take) m_pc = t;
            m_req = m_pc;
        end else if (m_held) begin
            if (take) begin
                m_held = 0;
                m_pc   = t;
                m_req  = t;
            end else if (rdy) begin
                m_held = 0;
                m_pc   = m_pc + 32'd4;
                m_req  = m_pc;
            end
        end else if (ack) begin
            if (take) m_pc = t;
            if (take || m_stale) begin
                m_stale = 0;
                m_req   = m_pc;
            end else begin
                m_held = 1;
                m_hpc  = m_req;
                m_hin  = rd;
            end
        end else if (take) begin
            m_pc    = t;
            m_stale = 1;
        end
    endtask

    // Called just after a negedge: drive, clock, advance model, check at next negedge.
    task automatic step(input bit rv, input logic [31:0] ra,
                        input bit ack, input logic [31:0] rd, input bit rdy);
        redirect_valid = rv;
        redirect_addr  = ra;
        imem_ack       = ack;
        imem_rdata     = rd;
        if_ready       = rdy;
        @(posedge clk);
        model_update(rv, ra, ack, rd, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        rst = 1'b0;

        // Sequential fetch 0,4,8
        step(0, 0, 0, 0, 1);
        chk("seq_addr0", imem_addr, 32'h0);
        step(0, 0, 1, 32'hA000_0000, 1);
        chk("seq_pc0", if_pc, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("seq_addr4", imem_addr, 32'h4);
        step(0, 0, 1, 32'hA000_0004, 0);

        // Decode stall in HOLD
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 32'hBAD0_0000, 0);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_instr", if_instr, 32'hA000_0004);
        end
        step(0, 0, 0, 0, 1);
        chk("seq_addr8", imem_addr, 32'h8);

        // Redirect during REQ with delayed ack
        step(1, 32'h100, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("drain_addr", imem_addr, 32'h8);
        step(0, 0, 1, 32'hDEAD_BEEF, 1);
        chk("drain_next", imem_addr, 32'h100);
        chk("drain_novalid", {31'b0, if_valid}, 32'h0);

        // Two redirects while draining
        step(1, 32'h200, 0, 0, 1);
        step(1, 32'h300, 0, 0, 1);
        step(0, 0, 1, 32'hDEAD_0001, 1);
        chk("latest_wins", imem_addr, 32'h300);

        // Redirect in HOLD with if_ready
        step(0, 0, 1, 32'hA000_0300, 0);
        step(1, 32'h40, 0, 0, 1);
        chk("hold_redir", imem_addr, 32'h40);
        chk("hold_drop", {31'b0, if_valid}, 32'h0);

        // Wrap at top of address space
        step(1, 32'hFFFF_FFFC, 1, 32'hDEAD_0002, 1);
        step(0, 0, 1, 32'hA0FF_FFFC, 1);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned redirect
        step(1, 32'h102, 0, 0, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
        chk("mis_ignored", imem_addr, 32'h0);
        step(0, 0, 1, 32'hA000_0000, 1);
        chk("mis_gone", {31'b0, misalign_err}, 32'h0);
        chk("mis_fetch", if_pc, 32'h0);
`else
        step(0, 0, 1, 32'hDEAD_0003, 1);
        chk("mis_forced", imem_addr, 32'h100);
`endif
        step(0, 0, 0, 0, 1);

        // Reset mid-request drops imem_req without a clock edge
        #2 rst = 1'b1;
        #1 chk("async_rst_req", {31'b0, imem_req}, 32'h0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          rv;
            logic [31:0] ra;
            rv = ($urandom_range(0, 5) == 0);
            ra = $urandom();
            if ($urandom_range(0, 3) == 0) ra = ra & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFC;
            step(rv, ra, $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
